// File: rtl/nmc_alu_sched.sv
// Round-robin scheduler that time-shares one near-memory ALU among NUM_REQ requesters.
// Accepts at T, drives the ALU for T+1..T+ALU_LATENCY, then holds the response until consumed.
module nmc_alu_sched #(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 2,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int ALU_LATENCY = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
    output logic [DATA_WIDTH-1:0]          alu_a_o,
    output logic [DATA_WIDTH-1:0]          alu_b_o,
    output logic [OP_WIDTH-1:0]            alu_op_o,
    output logic                           alu_en_o,
    input  logic [DATA_WIDTH-1:0]          alu_c_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [ID_WIDTH-1:0]            resp_id_o,
    output logic [DATA_WIDTH-1:0]          resp_data_o,
    output logic                           busy_o
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);
    localparam logic [ID_WIDTH-1:0] ID_LAST = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [OP_WIDTH-1:0]    op_q, op_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d;
    logic [DATA_WIDTH-1:0]  b_q, b_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  res_q, res_d;

    logic                   win_vld;
    logic [ID_WIDTH-1:0]    win_id;
    logic [ID_WIDTH-1:0]    rr_idx;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        rr_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_vld && req_valid_i[rr_idx]) begin
                win_vld = 1'b1;
                win_id  = rr_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        req_ready_o  = '0;
        alu_en_o     = 1'b0;
        resp_valid_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Ready is gated by reset so nothing is offered while held in reset.
                if (win_vld && rst_n_i) begin
                    req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                    id_d        = win_id;
                    op_d        = req_op_i[win_id*OP_WIDTH +: OP_WIDTH];
                    a_d         = req_a_i[win_id*DATA_WIDTH +: DATA_WIDTH];
                    b_d         = req_b_i[win_id*DATA_WIDTH +: DATA_WIDTH];
                    rr_ptr_d    = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = alu_c_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    // Operand latches stay on the ALU port outside EXEC; only alu_en_o marks validity.
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_op_o    = op_q;
    assign resp_id_o   = id_q;
    assign resp_data_o = res_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
